conv_frame_ctrl: RTL and testbench

Frame-level sequencer for the 28x28, 5x5 convolution engine. On `start` it clears the engine, streams one frame from pixel RAM as a single contiguous valid burst, collects the 24x24 results into a result RAM, and signals `done` with an error flag. It sits between the frame buffers and the convolution datapath. Its purpose is to make the engine re-usable frame after frame, because the engine's internal counters recover only through reset.

---
 rtl/conv_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_conv_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_ctrl.sv
// ============================================================================
//  Module : conv_frame_ctrl
//  Frame sequencer for the 28x28 / 5x5 convolution engine: clear, stream one
//  frame of pixels, collect results, report done/err.
//  Optional macro CONV_CTRL_RELU_EN clamps negative results to zero.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module conv_frame_ctrl #(
    parameter int PIX_NUM       = 784,
    parameter int OUT_NUM       = 576,
    parameter int CLR_CYCLES    = 2,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               pix_rd_en,
    output logic [9:0]         pix_addr,
    input  logic signed [15:0] pix_rd_data,
    output logic               conv_rst_n,
    output logic               conv_pic_valid,
    output logic signed [15:0] conv_data_pic,
    input  logic               conv_out_valid,
    input  logic signed [32:0] conv_data_out,
    output logic               res_we,
    output logic [9:0]         res_addr,
    output logic signed [32:0] res_data
);

    localparam int c_CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int c_TO_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    localparam logic [c_CLR_W-1:0] c_CLR_LAST = c_CLR_W'(CLR_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(DRAIN_TIMEOUT - 1);
    localparam logic [9:0]         c_PIX_LAST = 10'(PIX_NUM - 1);
    localparam logic [9:0]         c_OUT_NUM  = 10'(OUT_NUM);
    localparam logic [9:0]         c_OUT_LAST = 10'(OUT_NUM - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CLR   = 3'd1;
    localparam logic [2:0] c_ST_FEED  = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CLR_W-1:0] r_clr_cnt;
    logic [9:0]         r_pix_cnt;
    logic [9:0]         r_res_cnt;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic               r_err;
    logic               r_conv_rst_n;
    logic               r_pic_valid;
    logic               r_res_we;
    logic [9:0]         r_res_addr;
    logic signed [32:0] r_res_data;
    logic signed [32:0] w_res_val;
    logic               w_feed;
    logic               w_capture;
    logic               w_all_in;
    logic               w_err_nxt;

`ifdef CONV_CTRL_RELU_EN
    assign w_res_val = conv_data_out[32] ? 33'sd0 : conv_data_out;
`else
    assign w_res_val = conv_data_out;
`endif

    always_comb begin
        w_feed    = (r_state == c_ST_FEED);
        w_capture = conv_out_valid && (r_res_cnt < c_OUT_NUM) &&
                    ((r_state == c_ST_FEED) || (r_state == c_ST_DRAIN));
        w_all_in  = (r_res_cnt == c_OUT_NUM);
        // A result landing on the timeout cycle still completes the frame.
        w_err_nxt = !(w_all_in || (w_capture && (r_res_cnt == c_OUT_LAST)));
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_nxt = c_ST_CLR;
            c_ST_CLR:   if (r_clr_cnt == c_CLR_LAST) w_state_nxt = c_ST_FEED;
            c_ST_FEED:  if (r_pix_cnt == c_PIX_LAST) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_all_in || (r_to_cnt == c_TO_LAST)) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_clr_cnt    <= '0;
            r_pix_cnt    <= '0;
            r_res_cnt    <= '0;
            r_to_cnt     <= '0;
            r_err        <= 1'b0;
            r_conv_rst_n <= 1'b0;
            r_pic_valid  <= 1'b0;
            r_res_we     <= 1'b0;
            r_res_addr   <= '0;
            r_res_data   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_conv_rst_n <= (w_state_nxt != c_ST_CLR);
            r_pic_valid  <= w_feed;
            r_res_we     <= w_capture;
            if (w_capture) begin
                r_res_addr <= r_res_cnt;
                r_res_data <= w_res_val;
                r_res_cnt  <= r_res_cnt + 10'd1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_err     <= 1'b0;
                        r_clr_cnt <= '0;
                        r_pix_cnt <= '0;
                        r_res_cnt <= '0;
                        r_to_cnt  <= '0;
                    end
                end
                c_ST_CLR:   r_clr_cnt <= r_clr_cnt + 1'b1;
                c_ST_FEED:  r_pix_cnt <= r_pix_cnt + 10'd1;
                c_ST_DRAIN: begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                    if (w_state_nxt == c_ST_DONE) r_err <= w_err_nxt;
                end
                default: ;
            endcase
        end
    end

    assign busy           = (r_state != c_ST_IDLE);
    assign done           = (r_state == c_ST_DONE);
    assign err            = r_err;
    assign pix_rd_en      = w_feed;
    assign pix_addr       = w_feed ? r_pix_cnt : 10'd0;
    assign conv_rst_n     = r_conv_rst_n;
    assign conv_pic_valid = r_pic_valid;
    assign conv_data_pic  = r_pic_valid ? pix_rd_data : 16'sd0;
    assign res_we         = r_res_we;
    assign res_addr       = r_res_addr;
    assign res_data       = r_res_data;

endmodule

`default_nettype wire

// File: tb/tb_conv_frame_ctrl.sv
// ============================================================================
//  Module : tb_conv_frame_ctrl
//  Directed self-checking bench for conv_frame_ctrl with a simple engine model.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_conv_frame_ctrl;

    localparam int PIX_NUM       = 784;
    localparam int OUT_NUM       = 576;
    localparam int CLR_CYCLES    = 2;
    localparam int DRAIN_TIMEOUT = 64;
    localparam int RES_T0        = 260;   // frame cycle of the first model result

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               busy;
    logic               done;
    logic               err;
    logic               pix_rd_en;
    logic [9:0]         pix_addr;
    logic signed [15:0] pix_rd_data;
    logic               conv_rst_n;
    logic               conv_pic_valid;
    logic signed [15:0] conv_data_pic;
    logic               conv_out_valid;
    logic signed [32:0] conv_data_out;
    logic               res_we;
    logic [9:0]         res_addr;
    logic signed [32:0] res_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    conv_frame_ctrl #(
        .PIX_NUM(PIX_NUM), .OUT_NUM(OUT_NUM),
        .CLR_CYCLES(CLR_CYCLES), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_rd_data(pix_rd_data),
        .conv_rst_n(conv_rst_n), .conv_pic_valid(conv_pic_valid),
        .conv_data_pic(conv_data_pic), .conv_out_valid(conv_out_valid),
        .conv_data_out(conv_data_out), .res_we(res_we), .res_addr(res_addr),
        .res_data(res_data)
    );

    function automatic logic signed [15:0] pixf(input logic [9:0] a);
        return {a, 6'b0} ^ 16'hA5C3;
    endfunction

    function automatic logic signed [32:0] resval(input int j);
        if (j == 0) return -33'sd5;
        if (j == 1) return 33'sd7;
        return 33'(j * 3 - 900);
    endfunction

    function automatic logic signed [32:0] exp_res(input int j);
        logic signed [32:0] v;
        v = resval(j);
`ifdef CONV_CTRL_RELU_EN
        if (v < 0) v = 33'sd0;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Starts a frame (start sampled at edge 0), steps cycle by cycle with the
    // pixel RAM and engine models, then checks the frame-level statistics.
    task automatic run_frame(input string nm, input int n_res, input int pulse_at,
                             input bit hold, input int exp_done_k, input bit exp_err,
                             input bit chk_err_clear);
        int k = 0;
        int clr_n = 0, first_clr = -1;
        int rd_n = 0, first_rd = -1, last_rd = -1, rd_err = 0;
        int v_n = 0, first_v = -1, last_v = -1, pix_err = 0;
        int wr_n = 0, wr_max = -1, wr_err = 0, data_err = 0;
        int done_n = 0, done_k = -1;
        logic err_done = 1'b0, busy_after = 1'b1, err_k1 = 1'b1;
        logic prev_rd = 1'b0;
        logic [9:0] prev_addr = '0;
        logic signed [15:0] exp_pix;
        logic signed [32:0] wd0 = '0, wd1 = '0;

        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        k = 1;
        while (k < 1500 && (done_k < 0 || k <= done_k + 1)) begin
            if (prev_rd) begin
                pix_rd_data = pixf(prev_addr);
                exp_pix     = pixf(prev_addr);
            end else begin
                pix_rd_data = 16'sh1234;
                exp_pix     = 16'sd0;
            end
            conv_out_valid = (k >= RES_T0) && (k < RES_T0 + n_res);
            conv_data_out  = resval(k - RES_T0);
            if (!hold) start = (k == pulse_at);
            #1;
            if (k == 1) err_k1 = err;
            if (!conv_rst_n) begin
                clr_n++;
                if (first_clr < 0) first_clr = k;
            end
            if (pix_rd_en) begin
                if (first_rd < 0) first_rd = k;
                if (pix_addr !== 10'(rd_n)) rd_err++;
                rd_n++;
                last_rd = k;
            end
            if (conv_pic_valid) begin
                v_n++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
            if (conv_data_pic !== exp_pix) pix_err++;
            if (res_we) begin
                if (res_addr !== 10'(wr_n)) wr_err++;
                if (res_data !== exp_res(wr_n)) data_err++;
                if (wr_n == 0) wd0 = res_data;
                if (wr_n == 1) wd1 = res_data;
                if (int'(res_addr) > wr_max) wr_max = int'(res_addr);
                wr_n++;
            end
            if (done_k >= 0 && k == done_k + 1) busy_after = busy;
            if (done) begin
                done_n++;
                done_k   = k;
                err_done = err;
            end
            prev_rd   = pix_rd_en;
            prev_addr = pix_addr;
            @(posedge clk); #1;
            k++;
        end
        conv_out_valid = 1'b0;
        if (!hold) start = 1'b0;

        if (chk_err_clear) chk({nm, " err_cleared_by_start"}, err_k1, 0);
        chk({nm, " clr_cycles"},      clr_n, CLR_CYCLES);
        chk({nm, " clr_first"},       first_clr, 1);
        chk({nm, " reads"},           rd_n, PIX_NUM);
        chk({nm, " read_first"},      first_rd, CLR_CYCLES + 1);
        chk({nm, " read_span"},       last_rd - first_rd + 1, PIX_NUM);
        chk({nm, " read_addr_errs"},  rd_err, 0);
        chk({nm, " valid_count"},     v_n, PIX_NUM);
        chk({nm, " valid_first"},     first_v, CLR_CYCLES + 2);
        chk({nm, " valid_last"},      last_v, CLR_CYCLES + PIX_NUM + 1);
        chk({nm, " pix_data_errs"},   pix_err, 0);
        chk({nm, " writes"},          wr_n, (n_res < OUT_NUM) ? n_res : OUT_NUM);
        chk({nm, " write_addr_max"},  wr_max, ((n_res < OUT_NUM) ? n_res : OUT_NUM) - 1);
        chk({nm, " write_addr_errs"}, wr_err, 0);
        chk({nm, " write_data_errs"}, data_err, 0);
        chk({nm, " res_data0"},       wd0, exp_res(0));
        chk({nm, " res_data1"},       wd1, exp_res(1));
        chk({nm, " done_pulses"},     done_n, 1);
        chk({nm, " done_cycle"},      done_k, exp_done_k);
        chk({nm, " err_at_done"},     err_done, exp_err);
        chk({nm, " busy_after_done"}, busy_after, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        pix_rd_data    = 16'sh1234;
        conv_out_valid = 1'b0;
        conv_data_out  = '0;

        #12;
        chk("rst busy",       busy, 0);
        chk("rst done",       done, 0);
        chk("rst err",        err, 0);
        chk("rst pix_rd_en",  pix_rd_en, 0);
        chk("rst pix_addr",   pix_addr, 0);
        chk("rst conv_rst_n", conv_rst_n, 0);
        chk("rst pic_valid",  conv_pic_valid, 0);
        chk("rst data_pic",   conv_data_pic, 0);
        chk("rst res_we",     res_we, 0);
        chk("rst res_data",   res_data, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rel conv_rst_n_before_edge", conv_rst_n, 0);
        @(posedge clk); #1;
        chk("rel conv_rst_n_after_edge", conv_rst_n, 1);
        repeat (2) @(posedge clk);
        #1;

        // Complete frame: last result at 835, written 836, done 837.
        run_frame("f1", OUT_NUM, -1, 1'b0, 837, 1'b0, 1'b0);

        // One result short: DRAIN entered at 787, timeout done 64 cycles later.
        run_frame("f2", OUT_NUM - 1, -1, 1'b0, 787 + DRAIN_TIMEOUT, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("f2 err_held_idle", err, 1);
        chk("f2 busy_idle",     busy, 0);

        // Surplus results plus a stray start during FEED.
        run_frame("f3", OUT_NUM + 4, 400, 1'b0, 837, 1'b0, 1'b1);

        // start held high: next frame begins right after IDLE with a fresh CLR.
        run_frame("f4", OUT_NUM, -1, 1'b1, 837, 1'b0, 1'b0);
        chk("b2b clr_a conv_rst_n", conv_rst_n, 0);
        chk("b2b clr_a busy",       busy, 1);
        @(posedge clk); #1;
        chk("b2b clr_b conv_rst_n", conv_rst_n, 0);
        @(posedge clk); #1;
        chk("b2b feed conv_rst_n",  conv_rst_n, 1);
        chk("b2b feed pix_rd_en",   pix_rd_en, 1);
        chk("b2b feed pix_addr",    pix_addr, 0);
        start = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        chk("mid pix_addr", pix_addr, 400);

        // Asynchronous reset in the middle of FEED.
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy",       busy, 0);
        chk("arst done",       done, 0);
        chk("arst err",        err, 0);
        chk("arst pix_rd_en",  pix_rd_en, 0);
        chk("arst pix_addr",   pix_addr, 0);
        chk("arst conv_rst_n", conv_rst_n, 0);
        chk("arst pic_valid",  conv_pic_valid, 0);
        chk("arst data_pic",   conv_data_pic, 0);
        chk("arst res_we",     res_we, 0);
        chk("arst res_addr",   res_addr, 0);
        chk("arst res_data",   res_data, 0);
        repeat (2) @(posedge clk);
        #1 chk("arst no_done", done, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame("f5", OUT_NUM, -1, 1'b0, 837, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
